// File: rtl/wca_read_word_fifo_reg_if.sv
// wca_read_word_fifo_reg_if: fabric push side, status flags and rbus control for the read-word FIFO.
// The tri-state rbusData byte lane stays a plain inout port of the register.
interface wca_read_word_fifo_reg_if #(parameter int DEPTH_LOG2 = 3);
    logic [15:0]         in;
    logic                in_nd;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic [11:0]         rbusCtrl;

    modport master (output in, in_nd, rbusCtrl, input full, empty, count, overflow);
    modport slave  (input in, in_nd, rbusCtrl, output full, empty, count, overflow);
endinterface

// File: rtl/wca_read_word_fifo_reg.sv
// wca_read_word_fifo_reg: host-readable 16-bit word FIFO drained as low byte then high byte on rbus.
// Optional sticky overflow flag with 0xFF empty reads: define WCA_READ_WORD_OVERFLOW_EN.
module wca_read_word_fifo_reg #(
    parameter logic [7:0] my_addr    = 8'h00,
    parameter int         DEPTH_LOG2 = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    wca_read_word_fifo_reg_if.slave   bus,
    inout  wire  [7:0]                rbusData
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, rd_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q, ovf_q, ovf_d;
    logic                  sel_q, hold_valid_q;
    logic [15:0]           hold_q, head;
    logic                  addr_valid, rd, strobe, pop, push;
    logic [7:0]            rdata, empty_byte;

    always_comb begin
        addr_valid = bus.rbusCtrl[11:4] == my_addr;
        rd         = addr_valid & bus.rbusCtrl[3];
        strobe     = addr_valid & bus.rbusCtrl[1];
        head       = mem_q[rd_q];
        pop        = strobe & sel_q & hold_valid_q;
        // a pop in the same clock frees the slot, so a push while full still lands
        push       = bus.in_nd & (~full_q | pop);
        count_d    = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
`ifdef WCA_READ_WORD_OVERFLOW_EN
        ovf_d      = pop ? 1'b0 : ovf_q | (bus.in_nd & full_q);
`else
        ovf_d      = 1'b0;
`endif
        empty_byte = ovf_q ? 8'hFF : 8'h00;
        rdata      = sel_q ? hold_q[15:8] : (empty_q ? empty_byte : head[7:0]);
    end

    assign rbusData     = (rd & reset) ? rdata : 8'hzz;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= bus.in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 1'b0;
            sel_q        <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            full_q  <= count_d == FULL_CNT;
            empty_q <= count_d == '0;
            ovf_q   <= ovf_d;
            sel_q   <= addr_valid & (sel_q ^ strobe);
            // leaving the address abandons a half-read word without popping it
            if (!addr_valid) begin
                hold_valid_q <= 1'b0;
            end else if (strobe) begin
                if (!sel_q) begin
                    hold_q       <= empty_q ? 16'h0000 : head;
                    hold_valid_q <= ~empty_q;
                end else begin
                    hold_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wca_read_word_fifo_reg.sv
// tb_wca_read_word_fifo_reg: table-driven cycle vectors plus hand sequences for async reset.
// An undriven rbusData floats to 0xFF through the pullup.
module tb_wca_read_word_fifo_reg;
    localparam logic [7:0] A = 8'h42;
    localparam logic [7:0] O = 8'h17;
`ifdef WCA_READ_WORD_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    typedef struct {
        logic        nd;
        logic [15:0] din;
        logic [7:0]  addr;
        logic        re, we, stb;
        logic [7:0]  dat;
        logic [3:0]  cnt;
        logic        ful, ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire [7:0] rbus_data;
    pullup (rbus_data);

    wca_read_word_fifo_reg_if #(.DEPTH_LOG2(3)) bus();

    wca_read_word_fifo_reg #(.my_addr(A), .DEPTH_LOG2(3)) dut (
        .clock(clk), .reset(rst_n), .bus(bus.slave), .rbusData(rbus_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    vec_t vq[$];

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk_flags(input string n, input logic [3:0] cnt, input logic ful, input logic ovf);
        chk({n, " count"}, {12'h0, bus.count}, {12'h0, cnt});
        chk({n, " empty"}, {15'h0, bus.empty}, {15'h0, cnt == 4'd0});
        chk({n, " full"}, {15'h0, bus.full}, {15'h0, ful});
        chk({n, " overflow"}, {15'h0, bus.overflow}, {15'h0, ovf & OVF});
    endtask

    function automatic vec_t mk(logic nd, logic [15:0] din, logic [7:0] addr, logic re, logic we,
                                logic stb, logic [7:0] dat, int cnt, logic ful, logic ovf);
        vec_t v;
        v.nd = nd; v.din = din; v.addr = addr; v.re = re; v.we = we; v.stb = stb;
        v.dat = dat; v.cnt = 4'(cnt); v.ful = ful; v.ovf = ovf;
        return v;
    endfunction

    function automatic vec_t psh(logic [15:0] din, int cnt, logic ful, logic ovf);
        return mk(1'b1, din, O, 1'b0, 1'b0, 1'b0, 8'hFF, cnt, ful, ovf);
    endfunction

    function automatic vec_t rdb(logic [7:0] dat, int cnt, logic ful, logic ovf);
        return mk(1'b0, 16'h0, A, 1'b1, 1'b0, 1'b1, dat, cnt, ful, ovf);
    endfunction

    task automatic apply(input vec_t x, input int i);
        @(negedge clk);
        bus.in_nd = x.nd;
        bus.in = x.din;
        bus.rbusCtrl = {x.addr, x.re, x.we, x.stb, 1'b0};
        #1 chk($sformatf("v%0d data", i), {8'h0, rbus_data}, {8'h0, x.dat});
        @(posedge clk);
        #1 chk_flags($sformatf("v%0d", i), x.cnt, x.ful, x.ovf);
    endtask

    initial begin
        bus.in_nd = 1'b0;
        bus.in = '0;
        bus.rbusCtrl = '0;

        vq.push_back(mk(1'b0, 16'h0, A, 1'b0, 1'b0, 1'b0, 8'hFF, 0, 1'b0, 1'b0));
        vq.push_back(psh(16'h1234, 1, 0, 0));
        vq.push_back(rdb(8'h34, 1, 0, 0));
        vq.push_back(rdb(8'h12, 0, 0, 0));
        vq.push_back(psh(16'hA001, 1, 0, 0));
        vq.push_back(psh(16'hA002, 2, 0, 0));
        vq.push_back(psh(16'hA003, 3, 0, 0));
        vq.push_back(rdb(8'h01, 3, 0, 0));
        vq.push_back(rdb(8'hA0, 2, 0, 0));
        vq.push_back(rdb(8'h02, 2, 0, 0));
        vq.push_back(rdb(8'hA0, 1, 0, 0));
        vq.push_back(rdb(8'h03, 1, 0, 0));
        vq.push_back(rdb(8'hA0, 0, 0, 0));
        vq.push_back(rdb(8'h00, 0, 0, 0));
        vq.push_back(rdb(8'h00, 0, 0, 0));
        vq.push_back(psh(16'h5566, 1, 0, 0));
        vq.push_back(mk(1'b0, 16'h0, A, 1'b0, 1'b1, 1'b0, 8'hFF, 1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 16'h0, A, 1'b1, 1'b0, 1'b0, 8'h66, 1, 1'b0, 1'b0));
        vq.push_back(rdb(8'h66, 1, 0, 0));
        vq.push_back(rdb(8'h55, 0, 0, 0));
        for (int k = 0; k < 8; k++) vq.push_back(psh(16'h0100 + 16'(k), k + 1, k == 7, 0));
        vq.push_back(psh(16'hDEAD, 8, 1, 1));
        vq.push_back(rdb(8'h00, 8, 1, 1));
        vq.push_back(rdb(8'h01, 7, 0, 0));
        for (int k = 1; k < 8; k++) begin
            vq.push_back(rdb(8'(k), 8 - k, 0, 0));
            vq.push_back(rdb(8'h01, 7 - k, 0, 0));
        end
        vq.push_back(rdb(8'h00, 0, 0, 0));
        vq.push_back(rdb(8'h00, 0, 0, 0));
        vq.push_back(psh(16'hBEEF, 1, 0, 0));
        vq.push_back(rdb(8'hEF, 1, 0, 0));
        vq.push_back(mk(1'b0, 16'h0, O, 1'b1, 1'b0, 1'b1, 8'hFF, 1, 1'b0, 1'b0));
        vq.push_back(rdb(8'hEF, 1, 0, 0));
        vq.push_back(rdb(8'hBE, 0, 0, 0));
        vq.push_back(rdb(8'h00, 0, 0, 0));
        vq.push_back(rdb(8'h00, 0, 0, 0));
        vq.push_back(psh(16'h3031, 1, 0, 0));
        vq.push_back(psh(16'h3233, 2, 0, 0));
        vq.push_back(psh(16'h3435, 3, 0, 0));
        vq.push_back(rdb(8'h31, 3, 0, 0));
        vq.push_back(mk(1'b1, 16'h3637, A, 1'b1, 1'b0, 1'b1, 8'h30, 3, 1'b0, 1'b0));
        vq.push_back(rdb(8'h33, 3, 0, 0));
        vq.push_back(rdb(8'h32, 2, 0, 0));
        vq.push_back(rdb(8'h35, 2, 0, 0));
        vq.push_back(rdb(8'h34, 1, 0, 0));
        vq.push_back(rdb(8'h37, 1, 0, 0));
        vq.push_back(rdb(8'h36, 0, 0, 0));
        for (int k = 0; k < 8; k++) vq.push_back(psh(16'h4000 + 16'(k), k + 1, k == 7, 0));
        vq.push_back(rdb(8'h00, 8, 1, 0));
        vq.push_back(mk(1'b1, 16'h4008, A, 1'b1, 1'b0, 1'b1, 8'h40, 8, 1'b1, 1'b0));
        vq.push_back(rdb(8'h01, 8, 1, 0));

        #12 chk_flags("reset", 4'd0, 1'b0, 1'b0);
        chk("reset data", {8'h0, rbus_data}, 16'h00FF);
        @(negedge clk) rst_n = 1'b1;

        foreach (vq[i]) apply(vq[i], i);

        // host sits mid-pair on the high byte of 0x4001 when reset drops
        @(negedge clk);
        bus.in_nd = 1'b0;
        bus.rbusCtrl = {A, 4'b1000};
        #1 chk("pre-reset data", {8'h0, rbus_data}, 16'h0040);
        rst_n = 1'b0;
        #1 chk("async reset data", {8'h0, rbus_data}, 16'h00FF);
        chk_flags("async reset", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rbusCtrl = {A, 4'b1010};
        #1 chk("post-reset data", {8'h0, rbus_data}, 16'h0000);
        @(posedge clk);
        #1 chk_flags("post-reset", 4'd0, 1'b0, 1'b0);
        apply(rdb(8'h00, 0, 0, 0), 900);
        apply(psh(16'h7788, 1, 0, 0), 901);
        apply(rdb(8'h88, 1, 0, 0), 902);
        apply(rdb(8'h77, 0, 0, 0), 903);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/wca_read_word_fifo_reg.md
Name: wca_read_word_fifo_reg

Overview:
Host-readable 16-bit word register backed by a small FIFO, sitting on the internal rbus alongside the write-word registers.
- Fabric logic pushes 16-bit words; the host drains them as two sequential byte reads at one address: low byte first, then high byte.
- The pop occurs on the high-byte strobe, so each word is read coherently.
- Used for sample/status streams that the host polls, e.g. capture counters and telemetry words.

Parameters:
my_addr, 0, 8-bit rbus address this register decodes.
DEPTH_LOG2, 3, log2 of FIFO depth in 16-bit words (default 8 words).

Ports:
clock  input  1  block clock; same net as rbusCtrl[0] (bus clock); all state on its rising edge.
reset  input  1  asynchronous, active-low reset.
in  input  16  word to push.
in_nd  input  1  push strobe, one word per clock while high.
full  output  1  FIFO holds 2^DEPTH_LOG2 words.
empty  output  1  FIFO holds 0 words.
count  output  DEPTH_LOG2+1  words currently stored.
overflow  output  1  sticky: push attempted while full (see Optional Feature).
rbusCtrl  input  12  {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}.
rbusData  inout  8  tri-state bus data.

Behaviour:
- Decode
  - addrValid = (rbusCtrl[11:4] == my_addr).
  - rd = addrValid & rbusCtrl[3].
  - strobe = addrValid & rbusCtrl[1].
  - writeEnable (rbusCtrl[2]) is ignored; this register is read-only.
- Reset (reset low, async)
  - Pointers and count = 0; empty = 1, full = 0, overflow = 0.
  - select = 0; hold = 0x0000; hold_valid = 0.
  - rbusData = Z.
- Byte select
  - select is cleared whenever addrValid = 0.
  - Otherwise select toggles on each strobe clock.
  - A host access to another address therefore restarts the pair at the low byte.
- Low-byte phase (select = 0)
  - rbusData = empty ? 0x00 : head[7:0], driven combinationally while rd.
  - On strobe: hold <= empty ? 0x0000 : head; hold_valid <= ~empty; select -> 1.
- High-byte phase (select = 1)
  - rbusData = hold[15:8] while rd.
  - On strobe: if hold_valid, pop the head (rd pointer +1, wraps modulo depth); hold_valid <= 0; select -> 0.
  - If hold_valid = 0, the strobe does not pop.
- Drive rule: rbusData is driven only when rd = 1; otherwise it is high-Z. No drive during a write cycle to the same address.
- Push
  - in_nd & ~full: write in at the wr pointer; pointer +1, wraps modulo depth.
  - in_nd & full: word dropped; pointers unchanged.
- Simultaneous push and pop in one clock: both occur, count unchanged. A push while full with a pop in the same clock is accepted (full is evaluated with the pop).
- Flags: full, empty and count are registered and updated the same clock as the pointer change, so latency from push to a visible non-empty flag is 1 clock.
- Host abort: if addrValid drops between the low and high byte, select clears, hold_valid clears and no pop occurs. The next low-byte read re-reads the same head word.

Optional Feature:
Macro WCA_READ_WORD_OVERFLOW_EN.
- Defined
  - overflow is set on in_nd & full (unless a pop occurs in the same clock).
  - overflow is cleared by reset or by any pop.
  - While overflow = 1, low-byte reads of an empty FIFO return 0xFF instead of 0x00, so the host can see the loss.
- Undefined
  - overflow is tied 0.
  - Empty low-byte reads return 0x00.

Test Plan:
- Reset, then push 0x1234 and read at my_addr: low byte = 0x34, high byte = 0x12; empty = 1 and count = 0 after the high strobe.
- Push 0xA001, 0xA002, 0xA003 and read three words: the host receives 0xA001, 0xA002, 0xA003 in order.
- Fill 8 words (full = 1), push 0xDEAD: dropped, count = 8. With the macro, overflow = 1 and clears after the first pop.
- Read low byte of 0xBEEF, access another address, then re-read: low byte 0xEF again, high 0xBE, exactly one pop.
- Read with FIFO empty: both bytes 0x00 (0xFF low with the macro and overflow set), count stays 0, no pointer movement.
- With count = 3, push and high-byte pop in the same clock: count stays 3; assert reset low mid-pair: all flags reset asynchronously and rbusData = Z.
